// File: rtl/fetch_ir_stage.sv
// DLX fetch stage: program counter plus instruction register.
// Fetches the word at pc, holds it for decode until acked, then steps to the next PC.
module fetch_ir_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] inst,
  output logic [15:0] imm16,
  output logic        inst_valid,
  input  logic        inst_ack,
  input  logic        branch_taken,
  input  logic [31:0] ext_imm,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01
  } state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;
  logic        inst_valid_reg;
  logic [31:0] pc_next;

  assign pc_plus4 = pc_reg + 32'd4;

  // Branch outranks jump; ext_imm is already sign extended, so a negative offset wraps modulo 2^32.
  always_comb begin
    pc_next = pc_plus4;
    if (branch_taken) begin
      pc_next = pc_plus4 + (ext_imm << 2);
    end else if (jump) begin
      pc_next = {pc_plus4[31:28], inst_reg[25:0], 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      inst_reg       <= '0;
      inst_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        FETCH: begin
          if (imem_ready) begin
            inst_reg       <= imem_data;
            inst_valid_reg <= 1'b1;
            state_reg      <= HOLD;
          end
        end
        HOLD: begin
          if (inst_ack && inst_valid_reg) begin
            inst_valid_reg <= 1'b0;
            pc_reg         <= pc_next;
            state_reg      <= FETCH;
          end
        end
        default: begin
          inst_valid_reg <= 1'b0;
          state_reg      <= FETCH;
        end
      endcase
    end
  end

  // Request is the only output with a combinational input path: it drops as soon as reset rises.
  assign imem_req   = (state_reg == FETCH) && !reset;
  assign imem_addr  = pc_reg;
  assign pc         = pc_reg;
  assign inst       = inst_reg;
  assign imm16      = inst_reg[15:0];
  assign inst_valid = inst_valid_reg;

endmodule

// File: tb/tb_fetch_ir_stage.sv
// Directed bench for fetch_ir_stage: stimulus pushes expected fetches to a queue,
// a monitor pops one on every rising inst_valid and compares.
module tb_fetch_ir_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] inst;
  logic [15:0] imm16;
  logic        inst_valid;
  logic        inst_ack;
  logic        branch_taken;
  logic [31:0] ext_imm;
  logic        jump;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } txn_t;

  txn_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  fetch_ir_stage #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_data    (imem_data),
    .inst         (inst),
    .imm16        (imm16),
    .inst_valid   (inst_valid),
    .inst_ack     (inst_ack),
    .branch_taken (branch_taken),
    .ext_imm      (ext_imm),
    .jump         (jump),
    .pc           (pc),
    .pc_plus4     (pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: inputs driven before the rising edge, outputs sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_fetch(input logic [31:0] exp_pc, input logic [31:0] data, input int waits);
    txn_t t;
    t.pc   = exp_pc;
    t.inst = data;
    exp_q.push_back(t);
    imem_data = data;
    for (int i = 0; i < waits; i++) begin
      check("wait_req", 32'(imem_req), 32'd1);
      check("wait_addr", imem_addr, exp_pc);
      check("wait_valid", 32'(inst_valid), 32'd0);
      imem_ready = 1'b0;
      step();
    end
    check("fetch_req", 32'(imem_req), 32'd1);
    check("fetch_addr", imem_addr, exp_pc);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    check("valid_rise", 32'(inst_valid), 32'd1);
    check("hold_req", 32'(imem_req), 32'd0);
  endtask

  task automatic do_ack(input logic br, input logic jmp, input logic [31:0] ext,
                        input logic [31:0] exp_next);
    inst_ack     = 1'b1;
    branch_taken = br;
    jump         = jmp;
    ext_imm      = ext;
    step();
    inst_ack     = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    check("next_pc", pc, exp_next);
    check("next_pc_plus4", pc_plus4, exp_next + 32'd4);
    check("ack_valid", 32'(inst_valid), 32'd0);
    check("refetch_req", 32'(imem_req), 32'd1);
    check("refetch_addr", imem_addr, exp_next);
  endtask

  // Scoreboard monitor.
  initial begin
    logic prev_valid;
    txn_t t;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (inst_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_inst: got inst=%h want no instruction", inst);
        end else begin
          t = exp_q.pop_front();
          check("mon_inst", inst, t.inst);
          check("mon_pc", pc, t.pc);
          check("mon_imm16", {16'h0, imm16}, {16'h0, t.inst[15:0]});
          $display("txn pc=%h inst=%h imm16=%h", pc, inst, imm16);
        end
      end
      prev_valid = inst_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    imem_ready   = 1'b0;
    imem_data    = '0;
    inst_ack     = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
    ext_imm      = '0;
    @(negedge clk);
    step();
    check("rst_pc", pc, RPC);
    check("rst_pc_plus4", pc_plus4, RPC + 32'd4);
    check("rst_inst", inst, 32'h0);
    check("rst_imm16", {16'h0, imm16}, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    reset = 1'b0;
    #1;

    // Reset, zero-wait first fetch, ack in first HOLD cycle.
    do_fetch(32'h0000_0100, 32'h2001_0005, 0);
    do_ack(1'b0, 1'b0, 32'h0, 32'h0000_0104);

    // Three wait states, then a jump to 0x200.
    do_fetch(32'h0000_0104, 32'h0800_0080, 3);
    do_ack(1'b0, 1'b1, 32'h0, 32'h0000_0200);

    // Backward branch, then branch and jump together (branch wins).
    do_fetch(32'h0000_0200, 32'h1000_FFFE, 0);
    do_ack(1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_01FC);
    do_fetch(32'h0000_01FC, 32'h1400_0040, 1);
    do_ack(1'b1, 1'b1, 32'h0000_0003, 32'h0000_020C);

    // Far branch, jump within the upper nibble, then branch to the top word and wrap.
    do_fetch(32'h0000_020C, 32'h1000_0000, 0);
    do_ack(1'b1, 1'b0, 32'h0BFF_FF80, 32'h3000_0010);
    do_fetch(32'h3000_0010, 32'h0800_0100, 0);
    do_ack(1'b0, 1'b1, 32'h0, 32'h3000_0400);
    do_fetch(32'h3000_0400, 32'h1000_0001, 0);
    do_ack(1'b1, 1'b0, 32'h33FF_FEFE, 32'hFFFF_FFFC);
    do_fetch(32'hFFFF_FFFC, 32'hAC22_0004, 0);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    do_ack(1'b0, 1'b0, 32'h0, 32'h0000_0000);

    // Spurious ack (with branch) during FETCH.
    inst_ack     = 1'b1;
    branch_taken = 1'b1;
    ext_imm      = 32'h0000_0005;
    step();
    inst_ack     = 1'b0;
    branch_taken = 1'b0;
    check("spur_ack_pc", pc, 32'h0);
    check("spur_ack_valid", 32'(inst_valid), 32'd0);
    check("spur_ack_req", 32'(imem_req), 32'd1);
    check("spur_ack_inst", inst, 32'hAC22_0004);

    // Spurious ready during HOLD, with a second idle HOLD cycle.
    do_fetch(32'h0000_0000, 32'h3C01_1234, 0);
    imem_ready = 1'b1;
    imem_data  = 32'hFFFF_FFFF;
    step();
    imem_ready = 1'b0;
    check("spur_rdy_inst", inst, 32'h3C01_1234);
    check("spur_rdy_valid", 32'(inst_valid), 32'd1);
    check("spur_rdy_req", 32'(imem_req), 32'd0);
    check("spur_rdy_pc", pc, 32'h0);
    do_ack(1'b0, 1'b0, 32'h0, 32'h0000_0004);

    // Reset in the same cycle as a memory response.
    reset      = 1'b1;
    imem_ready = 1'b1;
    imem_data  = 32'hDEAD_BEEF;
    #1;
    check("rst_req_gated", 32'(imem_req), 32'd0);
    step();
    reset      = 1'b0;
    imem_ready = 1'b0;
    #1;
    check("rstf_inst", inst, 32'h0);
    check("rstf_valid", 32'(inst_valid), 32'd0);
    check("rstf_pc", pc, RPC);
    check("rstf_req", 32'(imem_req), 32'd1);

    // Reset while holding an instruction.
    do_fetch(32'h0000_0100, 32'h2002_0007, 0);
    do_ack(1'b0, 1'b0, 32'h0, 32'h0000_0104);
    do_fetch(32'h0000_0104, 32'h2003_0009, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rsth_inst", inst, 32'h0);
    check("rsth_valid", 32'(inst_valid), 32'd0);
    check("rsth_pc", pc, RPC);
    check("rsth_req", 32'(imem_req), 32'd1);

    // Fresh fetch after release.
    do_fetch(32'h0000_0100, 32'h2004_000B, 0);
    do_ack(1'b0, 1'b0, 32'h0, 32'h0000_0104);

    step();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ir_stage.md
# fetch_ir_stage

Instruction fetch stage with program counter and instruction register for the DLX datapath. It sits directly upstream of the immediate sign extender: it issues word fetches to instruction memory, latches the returned instruction, and presents `imm16` and the full instruction to decode and extend. It takes the extender's 32-bit result back (`ext_imm`) to form branch targets when it computes the next PC.

## Interface

**Parameters**
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be word aligned.

**Ports** (name, direction, width, meaning)
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: reset, synchronous and active-high.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address; always equals `pc`.
- `imem_ready` in 1: memory response valid this cycle.
- `imem_data` in 32: instruction word; sampled only when `imem_req & imem_ready`.
- `inst` out 32: instruction register.
- `imm16` out 16: `inst[15:0]`, feeds the extender.
- `inst_valid` out 1: `inst` holds an unconsumed instruction.
- `inst_ack` in 1: consumer retires the current instruction; honoured only while `inst_valid`.
- `branch_taken` in 1: sampled with the ack; selects the branch target.
- `ext_imm` in 32: sign-extended immediate of the current `inst`.
- `jump` in 1: sampled with the ack; selects the jump target.
- `pc` out 32: address of the current / in-flight instruction.
- `pc_plus4` out 32: `pc + 4` modulo 2^32; used for link and next-PC.

## Operation

**States:** FETCH, HOLD (2-bit encoding; unused codes go to FETCH).

**FETCH**
- `imem_req = 1`, gated low while `reset` is high.
- `imem_addr = pc`, held stable until `imem_ready`.
- On `imem_ready`: `inst <= imem_data`, `inst_valid <= 1`, next state HOLD.

**HOLD**
- `imem_req = 0`. `inst`, `pc` and `inst_valid` are held while `inst_ack = 0`.
- On `inst_ack`: `inst_valid <= 0`, `pc <= next_pc`, next state FETCH.

**Next-PC priority** (all arithmetic modulo 2^32, no overflow flag):
1. `branch_taken`: `pc_plus4 + (ext_imm << 2)`.
2. `jump`: `{pc_plus4[31:28], inst[25:0], 2'b00}`.
3. Otherwise: `pc_plus4`.

Branch beats jump when both are asserted.

**Wrap-around:** `pc = 32'hFFFF_FFFC` gives `pc_plus4 = 0`. A negative `ext_imm` subtracts normally.

**Ignored inputs**
- `inst_ack` while `inst_valid = 0`.
- `imem_ready` in HOLD.
- `branch_taken` and `jump` without an ack.

**Reset** (overrides everything, including mid-fetch and HOLD):
- `pc <= RESET_PC`, `inst <= 0`, `inst_valid <= 0`, state FETCH.
- Any response arriving in the reset cycle is discarded.

## Timing

**Reset values:** `pc = RESET_PC`, `pc_plus4 = RESET_PC + 4`, `inst = 0`, `imm16 = 0`, `inst_valid = 0`. `imem_req = 0` while `reset` is high.

**Latency**
- First cycle after reset deasserts: `imem_req = 1`, `imem_addr = RESET_PC`.
- `imem_ready` in cycle N gives `inst_valid = 1` and new `inst` in cycle N+1.
- `inst_ack` in cycle M gives new `pc` and `imem_req = 1` in cycle M+1.

**Throughput:** best case one instruction per 2 cycles (zero-wait memory, ack asserted in the first HOLD cycle).

**Output structure:** `imm16`, `imem_addr` and `pc_plus4` are combinational from registers only, with no input-to-output path. `imem_req` is the one exception: it has a combinational path from `reset`.

**Extender path:** `ext_imm` is combinational from `imm16`, so it must settle within the HOLD cycle in which the ack is given.

## Test plan

1. **Reset and first fetch.** `RESET_PC = 32'h100`, zero-wait memory returns 32'h2001_0005, ack in the first HOLD cycle.
   - `imem_addr` = 0x100, then 0x104.
   - `inst_valid` is high for exactly 1 cycle.
   - `imm16` = 16'h0005.
2. **Memory wait states.** `imem_ready` held low 3 cycles.
   - `imem_req` stays 1 and `imem_addr` is stable for 4 cycles.
   - `inst_valid` rises the cycle after `ready`.
3. **Backward branch.** `pc` = 0x200, `ext_imm` = 32'hFFFF_FFFE, `branch_taken` with ack.
   - Next `pc` = 0x1FC.
   - Then `branch_taken` and `jump` together with `inst[25:0] = 26'h40` give `pc` = `pc_plus4 + offset` (branch wins).
4. **Jump and wrap-around.**
   - `pc` = 0x3000_0010, jump with `inst[25:0] = 26'h100` gives `pc` = 0x3000_0400.
   - `pc` = 0xFFFF_FFFC, sequential ack gives `pc` = 0.
5. **Reset mid-operation.** `reset` asserted in the same cycle as `imem_ready`, then separately during HOLD.
   - `inst` stays 0 and `inst_valid` = 0.
   - `pc` = `RESET_PC` on the next cycle.
   - A fresh fetch starts after release.
6. **Spurious inputs.** `inst_ack` during FETCH, `imem_ready` during HOLD.
   - No change to `pc`, `inst` or state.
